// File: rtl/world_camera_transformer.sv
// world_camera_transformer: view transform (translate, then rotate) of world-space triangles.
// Optional near-plane culling is compiled in with WORLD_CAMERA_CULL_EN.
package world_camera_pkg;
   typedef struct packed {
      logic signed [31:0] x;
      logic signed [31:0] y;
      logic signed [31:0] z;
   } vec3_t;

   typedef struct packed {
      vec3_t       pos;
      logic [31:0] color;
   } vertex_t;

   typedef struct packed {
      vertex_t v0;
      vertex_t v1;
      vertex_t v2;
   } triangle_t;

   // rot_mtx[0..8] = R11,R12,R13,R21,...,R33 in Q16.16
   typedef struct packed {
      vec3_t            pos;
      logic [8:0][31:0] rot_mtx;
   } camera_t;

   typedef struct packed {
      triangle_t triangle;
      camera_t   cam;
   } world_camera_t;

   localparam int WC_W  = $bits(world_camera_t);
   localparam int TRI_W = $bits(triangle_t);

   function automatic logic signed [65:0] sx(input logic signed [31:0] v);
      return {{34{v[31]}}, v};
   endfunction

   function automatic logic signed [31:0] dot3_transform(
      input logic signed [31:0] a,
      input logic signed [31:0] b,
      input logic signed [31:0] c,
      input vec3_t              d
   );
      return 32'((sx(a) * sx(d.x) + sx(b) * sx(d.y) + sx(c) * sx(d.z)) >>> 16);
   endfunction
endpackage

module world_camera_transformer
   import world_camera_pkg::*;
`ifdef WORLD_CAMERA_CULL_EN
#(
   parameter logic signed [31:0] NEAR_Z = 32'sh0001_0000
)
`endif
(
   input  logic             clk,
   input  logic             rst,
   input  logic [WC_W-1:0]  world_camera,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [TRI_W-1:0] out_triangle,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
`ifdef WORLD_CAMERA_CULL_EN
   ,
   output logic [15:0]      culled_count
`endif
);
   typedef enum logic [1:0] {IDLE, PROCESS, DONE} state_e;

   state_e           state_q, state_d;
   world_camera_t    wc_q;
   logic [1:0]       vidx_q;
   logic             s1_valid_q;
   logic [1:0]       s1_idx_q;
   vec3_t            s1_d_q;
   logic [31:0]      s1_color_q;
   logic             s2_valid_q;
   logic [1:0]       s2_idx_q;
   vertex_t          s2_vtx_q;
   vertex_t [2:0]    res_q;
   triangle_t        slot_q;
   logic             out_valid_q;
   logic             issue, load, drop, all_near, slot_free;
   vertex_t          vsel;
   vec3_t            d_rot;
   logic [8:0][31:0] rm;

   assign rm        = wc_q.cam.rot_mtx;
   assign slot_free = !out_valid_q || out_ready;

`ifdef WORLD_CAMERA_CULL_EN
   logic [15:0] culled_q;
   assign all_near = (res_q[0].pos.z < NEAR_Z) &&
                     (res_q[1].pos.z < NEAR_Z) &&
                     (res_q[2].pos.z < NEAR_Z);
   assign culled_count = culled_q;
`else
   assign all_near = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid && in_ready) state_d = PROCESS;
         PROCESS: if (s2_valid_q && s2_idx_q == 2'd2) state_d = DONE;
         DONE:    if (all_near || slot_free) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == IDLE) && !rst;
      issue    = (state_q == PROCESS) && (vidx_q != 2'd3);
      load     = (state_q == DONE) && slot_free && !all_near;
      drop     = (state_q == DONE) && all_near;
   end

   always_comb begin
      unique case (vidx_q)
         2'd0:    vsel = wc_q.triangle.v0;
         2'd1:    vsel = wc_q.triangle.v1;
         default: vsel = wc_q.triangle.v2;
      endcase
   end

   always_comb begin
      d_rot.x = dot3_transform(rm[0], rm[1], rm[2], s1_d_q);
      d_rot.y = dot3_transform(rm[3], rm[4], rm[5], s1_d_q);
      d_rot.z = dot3_transform(rm[6], rm[7], rm[8], s1_d_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wc_q        <= '0;
         vidx_q      <= '0;
         s1_valid_q  <= 1'b0;
         s1_idx_q    <= '0;
         s1_d_q      <= '0;
         s1_color_q  <= '0;
         s2_valid_q  <= 1'b0;
         s2_idx_q    <= '0;
         s2_vtx_q    <= '0;
         res_q       <= '0;
         slot_q      <= '0;
         out_valid_q <= 1'b0;
`ifdef WORLD_CAMERA_CULL_EN
         culled_q    <= '0;
`endif
      end else begin
         if (in_valid && in_ready) begin
            wc_q   <= world_camera_t'(world_camera);
            vidx_q <= 2'd0;
         end else if (issue) begin
            vidx_q <= vidx_q + 2'd1;
         end
         s1_valid_q <= issue;
         s1_idx_q   <= vidx_q;
         s1_d_q.x   <= vsel.pos.x - wc_q.cam.pos.x;
         s1_d_q.y   <= vsel.pos.y - wc_q.cam.pos.y;
         s1_d_q.z   <= vsel.pos.z - wc_q.cam.pos.z;
         s1_color_q <= vsel.color;
         s2_valid_q     <= s1_valid_q;
         s2_idx_q       <= s1_idx_q;
         s2_vtx_q.pos   <= d_rot;
         s2_vtx_q.color <= s1_color_q;
         if (s2_valid_q) begin
            unique case (s2_idx_q)
               2'd0:    res_q[0] <= s2_vtx_q;
               2'd1:    res_q[1] <= s2_vtx_q;
               default: res_q[2] <= s2_vtx_q;
            endcase
         end
         // a load on the handshake edge replaces the old result and keeps valid high
         if (load) begin
            slot_q      <= {res_q[0], res_q[1], res_q[2]};
            out_valid_q <= 1'b1;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
`ifdef WORLD_CAMERA_CULL_EN
         if (drop) culled_q <= culled_q + 16'd1;
`endif
      end
   end

   assign out_triangle = slot_q;
   assign out_valid    = out_valid_q;
   assign busy         = (state_q != IDLE) || out_valid_q;

`ifndef WORLD_CAMERA_CULL_EN
   logic unused_drop;
   assign unused_drop = drop;
`endif
endmodule

// File: tb/tb_world_camera_transformer.sv
// Bench for world_camera_transformer: directed and random triangles checked
// against a plain-arithmetic view-transform model.
module tb_world_camera_transformer;
   import world_camera_pkg::*;

   localparam int ONE = 32'sh0001_0000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   world_camera_t wc_in = '0;
   triangle_t     out_tri;
   logic          in_ready, out_valid, busy;
`ifdef WORLD_CAMERA_CULL_EN
   logic [15:0]   culled_count;
`endif
   int tests_run = 0;
   int failed = 0;

   always #5 clk = ~clk;

   world_camera_transformer dut (
      .clk          (clk),
      .rst          (rst),
      .world_camera (wc_in),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_triangle (out_tri),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
`ifdef WORLD_CAMERA_CULL_EN
      .culled_count (culled_count),
`endif
      .busy         (busy)
   );

   function automatic vertex_t mk_vtx(input int x, input int y, input int z,
                                      input logic [31:0] c);
      vertex_t v;
      v.pos.x = x;
      v.pos.y = y;
      v.pos.z = z;
      v.color = c;
      return v;
   endfunction

   function automatic logic [8:0][31:0] ident();
      logic [8:0][31:0] r;
      r = '0;
      r[0] = ONE;
      r[4] = ONE;
      r[8] = ONE;
      return r;
   endfunction

   // camera-space vertex = R * (v - cam), each row a Q16.16 dot product
   function automatic triangle_t model(input world_camera_t w);
      vertex_t vin [3];
      vertex_t vo [3];
      int      r [9];
      int      d [3];
      int      o [3];
      longint  s;
      vin[0] = w.triangle.v0;
      vin[1] = w.triangle.v1;
      vin[2] = w.triangle.v2;
      for (int i = 0; i < 9; i++) r[i] = int'(w.cam.rot_mtx[i]);
      for (int k = 0; k < 3; k++) begin
         d[0] = vin[k].pos.x - w.cam.pos.x;
         d[1] = vin[k].pos.y - w.cam.pos.y;
         d[2] = vin[k].pos.z - w.cam.pos.z;
         for (int row = 0; row < 3; row++) begin
            s = longint'(r[3*row]) * d[0] + longint'(r[3*row+1]) * d[1]
              + longint'(r[3*row+2]) * d[2];
            o[row] = int'(s >>> 16);
         end
         vo[k] = mk_vtx(o[0], o[1], o[2], vin[k].color);
      end
      return {vo[0], vo[1], vo[2]};
   endfunction

   function automatic bit is_culled(input triangle_t t);
`ifdef WORLD_CAMERA_CULL_EN
      return (t.v0.pos.z < ONE) && (t.v1.pos.z < ONE) && (t.v2.pos.z < ONE);
`else
      return (t.v0.pos.z != t.v0.pos.z);
`endif
   endfunction

   function automatic world_camera_t rand_wc();
      world_camera_t w;
      w.triangle.v0 = mk_vtx($urandom, $urandom, $urandom, $urandom);
      w.triangle.v1 = mk_vtx($urandom, $urandom, $urandom, $urandom);
      w.triangle.v2 = mk_vtx($urandom, $urandom, $urandom, $urandom);
      w.cam.pos.x = $urandom;
      w.cam.pos.y = $urandom;
      w.cam.pos.z = $urandom;
      for (int i = 0; i < 9; i++)
         w.cam.rot_mtx[i] = int'($urandom_range(32'h40000, 0)) - 32'sh20000;
      return w;
   endfunction

   function automatic world_camera_t ident_wc();
      world_camera_t w;
      w.triangle.v0 = mk_vtx(ONE, 2*ONE, 3*ONE, 32'hAA0000);
      w.triangle.v1 = mk_vtx(2*ONE, 2*ONE, 3*ONE, 32'h00BB00);
      w.triangle.v2 = mk_vtx(ONE, 4*ONE, 5*ONE, 32'h0000CC);
      w.cam.pos.x = ONE;
      w.cam.pos.y = 2*ONE;
      w.cam.pos.z = 3*ONE;
      w.cam.rot_mtx = ident();
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input world_camera_t w, output bit ok);
      wc_in = w;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (in_ready) ok = 1'b1;
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input int maxc, output int n);
      n = 0;
      while (!out_valid && n < maxc) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wc_in = rand_wc();
      in_valid = 1'b1;
      step();
      step();
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         failed++;
         $display("FAIL reset_hold: in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
      end
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      tests_run++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         failed++;
         $display("FAIL reset_state: in_ready=%b busy=%b out_valid=%b want 1 0 0",
                  in_ready, busy, out_valid);
      end
      tests_run++;
      if (out_tri !== '0) begin
         failed++;
         $display("FAIL reset_tri: got %h want 0", out_tri);
      end
`ifdef WORLD_CAMERA_CULL_EN
      tests_run++;
      if (culled_count !== 16'd0) begin
         failed++;
         $display("FAIL reset_culled: got %0d want 0", culled_count);
      end
`endif
   endtask

   task automatic test_identity();
      triangle_t exp;
      bit ok;
      int n;
      exp = {mk_vtx(0, 0, 0, 32'hAA0000), mk_vtx(ONE, 0, 0, 32'h00BB00),
             mk_vtx(0, 2*ONE, 2*ONE, 32'h0000CC)};
      out_ready = 1'b1;
      send(ident_wc(), ok);
      wait_out(12, n);
      tests_run++;
      if (!ok || n !== 6 || out_valid !== 1'b1) begin
         failed++;
         $display("FAIL identity_latency: accepted=%b edges=%0d valid=%b want 1 6 1",
                  ok, n, out_valid);
      end
      tests_run++;
      if (in_ready !== 1'b1) begin
         failed++;
         $display("FAIL identity_in_ready: got %b want 1", in_ready);
      end
      tests_run++;
      if (out_tri !== exp) begin
         failed++;
         $display("FAIL identity_tri: got %h want %h", out_tri, exp);
      end
      step();
   endtask

   task automatic test_rotz();
      world_camera_t w;
      bit ok;
      int n;
      w = '0;
      w.triangle.v0 = mk_vtx(ONE, 0, 0, 32'h1);
      w.triangle.v1 = mk_vtx(0, ONE, 0, 32'h2);
      w.triangle.v2 = mk_vtx(0, 0, 2*ONE, 32'h3);
      w.cam.rot_mtx[1] = -ONE;
      w.cam.rot_mtx[3] = ONE;
      w.cam.rot_mtx[8] = ONE;
      out_ready = 1'b1;
      send(w, ok);
      wait_out(12, n);
      tests_run++;
      if (out_valid !== 1'b1 || out_tri.v0.pos !== {32'sd0, ONE, 32'sd0}) begin
         failed++;
         $display("FAIL rotz_v0: valid=%b got %h want %h", out_valid,
                  out_tri.v0.pos, {32'sd0, ONE, 32'sd0});
      end
      tests_run++;
      if (out_tri !== model(w)) begin
         failed++;
         $display("FAIL rotz_tri: got %h want %h", out_tri, model(w));
      end
      step();
   endtask

   task automatic test_wrap();
      world_camera_t w;
      bit ok;
      int n;
      w = '0;
      w.triangle.v0 = mk_vtx(ONE, 0, 2*ONE, 32'h5);
      w.triangle.v1 = mk_vtx(ONE, ONE, 2*ONE, 32'h6);
      w.triangle.v2 = mk_vtx(0, 0, 2*ONE, 32'h7);
      w.cam.pos.x = 32'sh8000_0000;
      w.cam.rot_mtx = ident();
      out_ready = 1'b1;
      send(w, ok);
      wait_out(12, n);
      tests_run++;
      if (out_valid !== 1'b1 || out_tri.v0.pos.x !== 32'sh8001_0000) begin
         failed++;
         $display("FAIL wrap_x: valid=%b got %h want 80010000", out_valid, out_tri.v0.pos.x);
      end
      tests_run++;
      if (out_tri !== model(w)) begin
         failed++;
         $display("FAIL wrap_tri: got %h want %h", out_tri, model(w));
      end
      step();
   endtask

   task automatic test_random();
      world_camera_t w;
      triangle_t exp;
      bit ok;
      int n;
`ifdef WORLD_CAMERA_CULL_EN
      logic [15:0] cc;
`endif
      out_ready = 1'b1;
      for (int t = 0; t < 8; t++) begin
         w = rand_wc();
         exp = model(w);
`ifdef WORLD_CAMERA_CULL_EN
         cc = culled_count;
`endif
         send(w, ok);
         wait_out(10, n);
         tests_run++;
         if (is_culled(exp)) begin
            if (out_valid !== 1'b0) begin
               failed++;
               $display("FAIL random_cull_%0d: out_valid=%b want 0", t, out_valid);
            end
`ifdef WORLD_CAMERA_CULL_EN
            tests_run++;
            if (culled_count !== cc + 16'd1) begin
               failed++;
               $display("FAIL random_cull_cnt_%0d: got %0d want %0d", t, culled_count, cc + 16'd1);
            end
`endif
         end else if (out_valid !== 1'b1 || n !== 6 || out_tri !== exp) begin
            failed++;
            $display("FAIL random_%0d: valid=%b edges=%0d got %h want %h",
                     t, out_valid, n, out_tri, exp);
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      world_camera_t a, b;
      bit ok_a, ok_b;
      int n;
      a = ident_wc();
      b = rand_wc();
      b.cam.rot_mtx = ident();
      b.cam.pos.z = 0;
      b.triangle.v0.pos.z = 3*ONE;
      out_ready = 1'b0;
      send(a, ok_a);
      wait_out(12, n);
      send(b, ok_b);
      for (int i = 0; i < 8; i++) step();
      tests_run++;
      if (!ok_a || !ok_b || out_valid !== 1'b1 || out_tri !== model(a)) begin
         failed++;
         $display("FAIL b2b_hold: acc=%b%b valid=%b got %h want %h",
                  ok_a, ok_b, out_valid, out_tri, model(a));
      end
      tests_run++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         failed++;
         $display("FAIL b2b_stall: in_ready=%b busy=%b want 0 1", in_ready, busy);
      end
      out_ready = 1'b1;
      step();
      tests_run++;
      if (out_valid !== 1'b1 || out_tri !== model(b)) begin
         failed++;
         $display("FAIL b2b_swap: valid=%b got %h want %h", out_valid, out_tri, model(b));
      end
      step();
      tests_run++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         failed++;
         $display("FAIL b2b_drain: valid=%b busy=%b want 0 0", out_valid, busy);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit seen;
      int n;
      out_ready = 1'b1;
      send(ident_wc(), ok);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      tests_run++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         failed++;
         $display("FAIL rstmid_ready: in_ready=%b busy=%b want 1 0", in_ready, busy);
      end
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         seen |= out_valid;
         step();
      end
      tests_run++;
      if (seen !== 1'b0) begin
         failed++;
         $display("FAIL rstmid_no_out: out_valid seen=%b want 0", seen);
      end
      send(ident_wc(), ok);
      wait_out(12, n);
      tests_run++;
      if (n !== 6 || out_tri !== model(ident_wc())) begin
         failed++;
         $display("FAIL rstmid_next: edges=%0d got %h want %h", n, out_tri, model(ident_wc()));
      end
      step();
   endtask

`ifdef WORLD_CAMERA_CULL_EN
   task automatic test_cull();
      world_camera_t w;
      logic [15:0] cc;
      bit ok, seen;
      int n;
      w = ident_wc();
      w.cam.pos = '0;
      w.triangle.v0.pos.z = 32'sh8000;
      w.triangle.v1.pos.z = 32'sh8000;
      w.triangle.v2.pos.z = 32'sh8000;
      out_ready = 1'b1;
      cc = culled_count;
      send(w, ok);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         seen |= out_valid;
         step();
      end
      tests_run++;
      if (seen !== 1'b0 || culled_count !== cc + 16'd1) begin
         failed++;
         $display("FAIL cull_near: seen=%b count=%0d want 0 %0d", seen, culled_count, cc + 16'd1);
      end
      w.triangle.v0.pos.z = 2*ONE;
      w.triangle.v1.pos.z = 2*ONE;
      w.triangle.v2.pos.z = 2*ONE;
      cc = culled_count;
      send(w, ok);
      wait_out(12, n);
      tests_run++;
      if (out_valid !== 1'b1 || out_tri !== model(w) || culled_count !== cc) begin
         failed++;
         $display("FAIL cull_far: valid=%b count=%0d got %h want %h", out_valid,
                  culled_count, out_tri, model(w));
      end
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_identity();
      test_rotz();
      test_wrap();
      test_random();
      test_back_to_back();
      test_reset_mid();
`ifdef WORLD_CAMERA_CULL_EN
      test_cull();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end
endmodule
